// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue controller in front of one lane's combinational ALU.
// Takes one instruction per valid/ready handshake, fetches 1-3 operands through
// a single register-file read port, drives the ALU, and writes the result back.
// It also keeps a sticky overflow flag and a count of retired instructions.

package warp_pkg;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_MUL  = 3'd1,
        OP_FMA  = 3'd2,
        OP_MAX  = 3'd3,
        OP_RELU = 3'd4
    } alu_opcode_e;
endpackage

module alu_issue_ctrl #(
    parameter int DATA_WIDTH = warp_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = 16,
    parameter int REG_AW     = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // instruction handshake from the sequencer
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  warp_pkg::alu_opcode_e  instr_opcode,
    input  logic [REG_AW-1:0]      instr_rd,
    input  logic [REG_AW-1:0]      instr_rs1,
    input  logic [REG_AW-1:0]      instr_rs2,
    input  logic [REG_AW-1:0]      instr_rs3,
    // register-file read port (data returns one cycle after the strobe)
    output logic                   rf_rd_en,
    output logic [REG_AW-1:0]      rf_rd_addr,
    input  logic [DATA_WIDTH-1:0]  rf_rd_data,
    // register-file write port
    output logic                   rf_wr_en,
    output logic [REG_AW-1:0]      rf_wr_addr,
    output logic [DATA_WIDTH-1:0]  rf_wr_data,
    // ALU interface
    output warp_pkg::alu_opcode_e  alu_opcode,
    output logic [DATA_WIDTH-1:0]  alu_operand1,
    output logic [DATA_WIDTH-1:0]  alu_operand2,
    output logic [DATA_WIDTH-1:0]  alu_operand3,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic                   alu_overflow,
    input  logic                   alu_ready,
    // status
    output logic                   ovf_sticky,
    input  logic                   ovf_clear,
    output logic [15:0]            retire_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4
    } state_e;

    // Number of register reads an opcode needs; unknown encodings read two.
    function automatic logic [1:0] op_count(input warp_pkg::alu_opcode_e op);
        case (op)
            warp_pkg::OP_RELU: return 2'd1;
            warp_pkg::OP_FMA:  return 2'd3;
            default:           return 2'd2;
        endcase
    endfunction

    state_e                 r_state;
    state_e                 w_next_state;
    logic [1:0]             r_cnt;
    warp_pkg::alu_opcode_e  r_opcode;
    warp_pkg::alu_opcode_e  r_alu_opcode;
    logic [REG_AW-1:0]      r_rd;
    logic [REG_AW-1:0]      r_rs1;
    logic [REG_AW-1:0]      r_rs2;
    logic [REG_AW-1:0]      r_rs3;
    logic [DATA_WIDTH-1:0]  r_op1;
    logic [DATA_WIDTH-1:0]  r_op2;
    logic [DATA_WIDTH-1:0]  r_op3;
    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_ovf;
    logic                   r_ovf_sticky;
    logic [15:0]            r_retire;

    logic [1:0]             w_nops;
    logic                   w_read_done;

    assign w_nops      = op_count(r_opcode);
    assign w_read_done = (r_cnt == 2'(w_nops - 2'd1));

    assign alu_opcode   = r_alu_opcode;
    assign alu_operand1 = r_op1;
    assign alu_operand2 = r_op2;
    assign alu_operand3 = r_op3;
    assign ovf_sticky   = r_ovf_sticky;
    assign retire_count = r_retire;

    // State register.
    // NOTE: sequential state is always written with non-blocking (<=) so every
    // flop samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and the strobes/addresses derived from the current state.
    // NOTE: every signal assigned here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        instr_ready  = 1'b0;
        rf_rd_en     = 1'b0;
        rf_rd_addr   = '0;
        rf_wr_en     = 1'b0;
        rf_wr_addr   = '0;
        rf_wr_data   = '0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                rf_rd_en = 1'b1;
                case (r_cnt)
                    2'd0:    rf_rd_addr = r_rs1;
                    2'd1:    rf_rd_addr = r_rs2;
                    default: rf_rd_addr = r_rs3;
                endcase
                if (w_read_done) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                if (alu_ready) begin
                    w_next_state = S_WB;
                end
            end
            S_WB: begin
                rf_wr_en     = 1'b1;
                rf_wr_addr   = r_rd;
                rf_wr_data   = r_result;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Instruction latch, operand collection, result capture and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_opcode     <= warp_pkg::alu_opcode_e'(0);
            r_alu_opcode <= warp_pkg::alu_opcode_e'(0);
            r_rd         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rs3        <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_op3        <= '0;
            r_result     <= '0;
            r_ovf        <= 1'b0;
            r_retire     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_opcode <= instr_opcode;
                        r_rd     <= instr_rd;
                        r_rs1    <= instr_rs1;
                        r_rs2    <= instr_rs2;
                        r_rs3    <= instr_rs3;
                        // Slots this opcode never reads must present zero to the ALU.
                        r_op1    <= '0;
                        r_op2    <= '0;
                        r_op3    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_READ: begin
                    // Data for the read issued last cycle arrives now.
                    case (r_cnt)
                        2'd1:    r_op1 <= rf_rd_data;
                        2'd2:    r_op2 <= rf_rd_data;
                        default: ;
                    endcase
                    if (!w_read_done) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_DRAIN: begin
                    // Final read's data lands in the last operand slot.
                    case (w_nops)
                        2'd1:    r_op1 <= rf_rd_data;
                        2'd2:    r_op2 <= rf_rd_data;
                        default: r_op3 <= rf_rd_data;
                    endcase
                    r_alu_opcode <= r_opcode;
                end
                S_EXEC: begin
                    if (alu_ready) begin
                        r_result <= alu_result;
                        r_ovf    <= alu_overflow;
                    end
                end
                S_WB: begin
                    r_retire <= r_retire + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Sticky overflow: a retiring overflow wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (r_state == S_WB && r_ovf) begin
            r_ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            r_ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against a
// register-file/ALU environment and an instruction-level reference model.

module tb_alu_issue_ctrl;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  instr_valid = 1'b0;
    logic                  instr_ready;
    warp_pkg::alu_opcode_e instr_opcode = warp_pkg::OP_ADD;
    logic [3:0]            instr_rd = '0;
    logic [3:0]            instr_rs1 = '0;
    logic [3:0]            instr_rs2 = '0;
    logic [3:0]            instr_rs3 = '0;
    logic                  rf_rd_en;
    logic [3:0]            rf_rd_addr;
    logic [31:0]           rf_rd_data = '0;
    logic                  rf_wr_en;
    logic [3:0]            rf_wr_addr;
    logic [31:0]           rf_wr_data;
    warp_pkg::alu_opcode_e alu_opcode;
    logic [31:0]           alu_operand1;
    logic [31:0]           alu_operand2;
    logic [31:0]           alu_operand3;
    logic [31:0]           alu_result;
    logic                  alu_overflow;
    logic                  alu_ready = 1'b1;
    logic                  ovf_sticky;
    logic                  ovf_clear = 1'b0;
    logic [15:0]           retire_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_pulses = 0;
    int last_accept = 0;
    logic [3:0] rd_log[$];

    // Reference state of the architectural registers and status.
    logic [31:0] ref_rf [16];
    logic        ref_sticky = 1'b0;
    logic [15:0] ref_retire = '0;

    // Register-file model with a backdoor preload port.
    logic [31:0] rf [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .instr_rs3    (instr_rs3),
        .rf_rd_en     (rf_rd_en),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .alu_opcode   (alu_opcode),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_operand3 (alu_operand3),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_ready    (alu_ready),
        .ovf_sticky   (ovf_sticky),
        .ovf_clear    (ovf_clear),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Signed arithmetic of each opcode on 32-bit operands; returns {overflow, result}.
    function automatic logic [32:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        longint sa, sb, sc, s;
        logic [63:0] su;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sc = longint'($signed(c));
        case (op)
            3'd0:    s = sa + sb;
            3'd1:    s = sa * sb;
            3'd2:    s = sa * sb + sc;
            3'd3:    s = (sa > sb) ? sa : sb;
            3'd4:    s = (sa > 0) ? sa : 64'sd0;
            default: s = sa + sb;
        endcase
        su = s;
        return {(s > MAXV) || (s < MINV), su[31:0]};
    endfunction

    assign {alu_overflow, alu_result} = alu_model(alu_opcode, alu_operand1, alu_operand2, alu_operand3);

    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
        if (rf_rd_en) rf_rd_data <= rf[rf_rd_addr];
    end

    always @(negedge clk) begin
        if (rf_wr_en) wr_pulses++;
        if (rf_rd_en) rd_log.push_back(rf_rd_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        ref_rf[a] = d;
    endtask

    // Issue one instruction (called at a negedge while the DUT is idle or about to be),
    // follow it to write-back and compare everything against the reference model.
    task automatic run_instr(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                             input logic [3:0] rs2, input logic [3:0] rs3,
                             input int stall, input bit hold, input bit clr_wb);
        int n, k, rd_base, wr_base;
        bit seen;
        logic [31:0] e1, e2, e3;
        logic [32:0] er;
        n  = (op == 3'd4) ? 1 : (op == 3'd2) ? 3 : 2;
        e1 = ref_rf[rs1];
        e2 = (n >= 2) ? ref_rf[rs2] : 32'd0;
        e3 = (n == 3) ? ref_rf[rs3] : 32'd0;
        er = alu_model(op, e1, e2, e3);
        rd_base = rd_log.size();
        wr_base = wr_pulses;

        instr_opcode = warp_pkg::alu_opcode_e'(op);
        instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_rs3 = rs3;
        instr_valid = 1'b1;
        alu_ready = (stall == 0);
        k = 0;
        while (!instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", instr_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        last_accept = cyc;
        if (!hold) instr_valid = 1'b0;
        check("busy_not_ready", instr_ready, 1'b0);

        k = 1;
        seen = 1'b0;
        while (k < 40 && !seen) begin
            if (rf_wr_en) begin
                seen = 1'b1;
            end else begin
                if (k >= n + 2) begin
                    check("exec_opcode", alu_opcode, op);
                    check("exec_op1", alu_operand1, e1);
                    check("exec_op2", alu_operand2, e2);
                    check("exec_op3", alu_operand3, e3);
                    if (k == n + 2 + stall) alu_ready = 1'b1;
                end
                @(negedge clk);
                k++;
            end
        end
        check("wb_seen", seen, 1'b1);
        check("wb_latency", k - 1, n + 2 + stall);
        check("wb_addr", rf_wr_addr, rd);
        check("wb_data", rf_wr_data, er[31:0]);
        check("wb_busy", instr_ready, 1'b0);
        if (clr_wb) ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;

        ref_sticky = er[32] ? 1'b1 : (clr_wb ? 1'b0 : ref_sticky);
        ref_retire = ref_retire + 16'd1;
        ref_rf[rd] = er[31:0];

        check("wr_pulse_count", wr_pulses - wr_base, 1);
        check("wr_en_dropped", rf_wr_en, 1'b0);
        check("ready_after_wb", instr_ready, 1'b1);
        check("read_count", rd_log.size() - rd_base, n);
        check("read_rs1", rd_log[rd_base], rs1);
        if (n >= 2) check("read_rs2", rd_log[rd_base + 1], rs2);
        if (n == 3) check("read_rs3", rd_log[rd_base + 2], rs3);
        check("ovf_sticky", ovf_sticky, ref_sticky);
        check("retire_count", retire_count, ref_retire);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, wr_base;
        for (int i = 0; i < 16; i++) begin
            rf[i] = '0;
            ref_rf[i] = '0;
        end

        // Reset state.
        #2;
        check("rst_ready", instr_ready, 1'b1);
        check("rst_rd_en", rf_rd_en, 1'b0);
        check("rst_wr_en", rf_wr_en, 1'b0);
        check("rst_opcode", alu_opcode, 3'd0);
        check("rst_op1", alu_operand1, 32'd0);
        check("rst_sticky", ovf_sticky, 1'b0);
        check("rst_retire", retire_count, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ADD 5+7.
        preload(4'd1, 32'd5);
        preload(4'd2, 32'd7);
        run_instr(3'd0, 4'd3, 4'd1, 4'd2, 4'd0, 0, 1'b0, 1'b0);

        // Signed overflow sets the sticky flag; clear during an overflowing WB loses.
        preload(4'd4, 32'h7FFF_FFFF);
        preload(4'd5, 32'd1);
        run_instr(3'd0, 4'd6, 4'd4, 4'd5, 4'd0, 0, 1'b0, 1'b0);
        run_instr(3'd0, 4'd7, 4'd4, 4'd5, 4'd0, 0, 1'b0, 1'b1);

        // A clear on its own takes effect on the next edge.
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        ref_sticky = 1'b0;
        check("ovf_clear_idle", ovf_sticky, 1'b0);

        // FMA 3*4+5 and RELU of a negative value.
        preload(4'd8, 32'd3);
        preload(4'd9, 32'd4);
        preload(4'd10, 32'd5);
        run_instr(3'd2, 4'd11, 4'd8, 4'd9, 4'd10, 0, 1'b0, 1'b0);
        preload(4'd12, 32'hFFFF_FFF6);
        run_instr(3'd4, 4'd13, 4'd12, 4'd0, 4'd0, 0, 1'b0, 1'b0);

        // Back-to-back dependent pair with valid held throughout.
        run_instr(3'd0, 4'd3, 4'd1, 4'd2, 4'd0, 0, 1'b1, 1'b0);
        a1 = last_accept;
        run_instr(3'd1, 4'd4, 4'd3, 4'd2, 4'd0, 0, 1'b0, 1'b0);
        a2 = last_accept;
        check("b2b_accept_gap", a2 - a1, 6);

        // Three-cycle ALU stall, then an overflowing multiply.
        run_instr(3'd3, 4'd14, 4'd8, 4'd9, 4'd0, 3, 1'b0, 1'b0);
        preload(4'd5, 32'h7FFF_FFFF);
        run_instr(3'd1, 4'd14, 4'd5, 4'd5, 4'd0, 0, 1'b0, 1'b0);

        // Reset while the instruction is stalled in EXEC.
        @(negedge clk);
        instr_opcode = warp_pkg::OP_ADD;
        instr_rd = 4'd15; instr_rs1 = 4'd1; instr_rs2 = 4'd2;
        instr_valid = 1'b1;
        alu_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", instr_ready, 1'b0);
        wr_base = wr_pulses;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ready", instr_ready, 1'b1);
        check("midrst_wr_en", rf_wr_en, 1'b0);
        check("midrst_rd_en", rf_rd_en, 1'b0);
        check("midrst_opcode", alu_opcode, 3'd0);
        check("midrst_op1", alu_operand1, 32'd0);
        check("midrst_op2", alu_operand2, 32'd0);
        check("midrst_sticky", ovf_sticky, 1'b0);
        check("midrst_retire", retire_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_write", wr_pulses - wr_base, 0);
        ref_sticky = 1'b0;
        ref_retire = '0;
        run_instr(3'd0, 4'd15, 4'd1, 4'd2, 4'd0, 0, 1'b0, 1'b0);

        // Randomized instruction stream, including undefined opcode encodings.
        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 0) preload(4'($urandom_range(0, 15)), $urandom);
            run_instr(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                      1'b0, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
